timer_ctrl: RTL

- Machine-timer controller that sequences a 64-bit free-running time counter and a 64-bit compare register for the core's CSR/MMIO path.
- Exposes the counter and compare through a 32-bit single-cycle request/response port.
- Applies a runtime prescaler and raises the machine timer interrupt when time >= compare.
- Sits between the load/store unit and the interrupt logic.

---
 rtl/timer_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: machine-timer controller with a 64-bit free-running time
// counter, 64-bit compare register, runtime prescaler and a 32-bit
// single-cycle request/response register port.
//
// Optional feature macro: TIMER_SHADOW_EN
//   defined   -> a time_lo read latches time[63:32] into a shadow that the
//                next time_hi read returns, giving an atomic 64-bit read.
//   undefined -> time_hi reads always return the live upper half.
//
// Register map (addr): 0 time_lo, 1 time_hi, 2 cmp_lo, 3 cmp_hi, 4 ctrl,
// 5-7 unmapped (read 0, writes ignored).
// ctrl: bit 0 = en, bits [8 +: DIV_WIDTH] = div.
module timer_ctrl #(
    parameter int          DIV_WIDTH = 8,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        timer_irq,
    input  logic        halt
);

    localparam int NUM_REGS = 5;

    // Architectural state
    logic [63:0]          time_reg, time_next;
    logic [63:0]          cmp_reg, cmp_next;
    logic                 en_reg, en_next;
    logic [DIV_WIDTH-1:0] div_reg, div_next;
    logic [DIV_WIDTH-1:0] presc_reg, presc_next;
    logic [31:0]          rdata_reg, rdata_next;
    logic                 rvalid_reg;
    logic                 irq_reg;

    // Decoded accesses
    logic [NUM_REGS-1:0] sel;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] rd_sel;
    logic                count_en;
    logic                tick;
    logic [31:0]         ctrl_rd;
    logic [31:0]         time_hi_rd;

    // One-hot register select plus qualified read/write strobes per register
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign sel[gi]    = (addr == 3'(gi));
            assign wr_sel[gi] = req & we & sel[gi];
            assign rd_sel[gi] = req & ~we & sel[gi];
        end
    endgenerate

    // The prescaler only advances while enabled and not debug-halted
    assign count_en = en_reg & ~halt;
    assign tick     = count_en & (presc_reg == div_reg);

`ifdef TIMER_SHADOW_EN
    logic [31:0] shadow_hi_reg, shadow_hi_next;
    logic        shadow_valid_reg, shadow_valid_next;

    // Shadow returns the upper half captured by the last time_lo read once
    assign time_hi_rd = shadow_valid_reg ? shadow_hi_reg : time_reg[63:32];

    // Capture on a time_lo read, consume on a time_hi read, drop on time writes
    always_comb begin
        shadow_hi_next    = shadow_hi_reg;
        shadow_valid_next = shadow_valid_reg;
        if (wr_sel[0] || wr_sel[1]) begin
            shadow_valid_next = 1'b0;
        end else if (rd_sel[0]) begin
            shadow_hi_next    = time_reg[63:32];
            shadow_valid_next = 1'b1;
        end else if (rd_sel[1]) begin
            shadow_valid_next = 1'b0;
        end
    end

    // Shadow storage update
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_hi_reg    <= '0;
            shadow_valid_reg <= 1'b0;
        end else begin
            shadow_hi_reg    <= shadow_hi_next;
            shadow_valid_reg <= shadow_valid_next;
        end
    end
`else
    assign time_hi_rd = time_reg[63:32];
`endif

    // ctrl readback: unused bits read as zero
    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[0]              = en_reg;
        ctrl_rd[8 +: DIV_WIDTH] = div_reg;
    end

    // Next-state for prescaler, counter, compare and ctrl
    always_comb begin
        presc_next = presc_reg;
        time_next  = time_reg;
        cmp_next   = cmp_reg;
        en_next    = en_reg;
        div_next   = div_reg;

        // A ctrl write restarts the prescaler so the new divisor takes
        // effect from a clean phase.
        if (wr_sel[4]) begin
            presc_next = '0;
            en_next    = wdata[0];
            div_next   = wdata[8 +: DIV_WIDTH];
        end else if (count_en) begin
            presc_next = tick ? '0 : presc_reg + DIV_WIDTH'(1);
        end

        // Software writes to time win over a tick; that tick is dropped.
        if (wr_sel[0]) begin
            time_next[31:0] = wdata;
        end else if (wr_sel[1]) begin
            time_next[63:32] = wdata;
        end else if (tick) begin
            time_next = time_reg + 64'd1;
        end

        if (wr_sel[2]) begin
            cmp_next[31:0] = wdata;
        end
        if (wr_sel[3]) begin
            cmp_next[63:32] = wdata;
        end
    end

    // Read data reflects register values before any same-cycle update
    always_comb begin
        rdata_next = '0;
        if (req && !we) begin
            case (addr)
                3'd0:    rdata_next = time_reg[31:0];
                3'd1:    rdata_next = time_hi_rd;
                3'd2:    rdata_next = cmp_reg[31:0];
                3'd3:    rdata_next = cmp_reg[63:32];
                3'd4:    rdata_next = ctrl_rd;
                default: rdata_next = '0;
            endcase
        end
    end

    // Register all state; interrupt compares current values, so it lags by one cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            time_reg   <= '0;
            cmp_reg    <= CMP_RESET;
            en_reg     <= 1'b0;
            div_reg    <= '0;
            presc_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            irq_reg    <= 1'b0;
        end else begin
            time_reg   <= time_next;
            cmp_reg    <= cmp_next;
            en_reg     <= en_next;
            div_reg    <= div_next;
            presc_reg  <= presc_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= req;
            irq_reg    <= (time_reg >= cmp_reg);
        end
    end

    assign rdata     = rdata_reg;
    assign rvalid    = rvalid_reg;
    assign timer_irq = irq_reg;

endmodule
